control_cmd_reportbrightness: RTL and testbench
===============================================

Name: control_cmd_reportbrightness

Overview:
Response-side counterpart to the brightness-set command handler in the UART control path. It tracks the brightness value most recently committed by the set-command path. When the command decoder issues a query, it emits a fixed byte frame reporting that value to the UART transmitter over a valid/ready byte handshake. It sits between the control command decoder and the UART tx byte interface.

Parameters:
BRIGHTNESS_LEVELS, 6, width of the brightness value; legal range 1..8.
RESP_HEADER, 8'h42, first byte of every response frame.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
brightness_in  input  BRIGHTNESS_LEVELS  new brightness value from the set-command path
brightness_change_en  input  1  one-cycle strobe; latch brightness_in
enable  input  1  one-cycle query request from the command decoder
tx_ready  input  1  UART tx can accept a byte this cycle
tx_data  output  8  response byte
tx_valid  output  1  tx_data is valid; held until accepted
busy  output  1  frame in progress (state != IDLE)
done  output  1  one-cycle pulse after the final byte is accepted

Behaviour:
- Clocking and reset
  - All state on posedge clk.
  - reset is synchronous, active-high, and overrides everything else.
  - Reset values: tx_data=0, tx_valid=0, busy=0, done=0, stored brightness=0, state=IDLE.
  - Reset mid-frame aborts the frame; tx_valid is 0 after that edge and no further bytes follow.
- Brightness register
  - On any cycle with brightness_change_en=1, the register loads brightness_in, regardless of state.
- Snapshot at query
  - On enable in IDLE, snapshot the value to report.
  - If brightness_change_en=1 in that same cycle, the snapshot is brightness_in (bypass). Otherwise it is the stored register.
  - Updates arriving mid-frame change the register only, never the in-flight frame.
- Value byte
  - Value byte = snapshot zero-extended to 8 bits.
- Handshake
  - A byte transfers on a cycle with tx_valid=1 and tx_ready=1.
  - While tx_valid=1 and tx_ready=0, tx_data must remain stable.
  - tx_valid never drops before acceptance, except on reset.
- States
  - IDLE: enable=1 -> SEND_HDR. On the next cycle tx_valid=1, tx_data=RESP_HEADER, busy=1.
  - SEND_HDR: on acceptance -> SEND_VAL. The next cycle presents the value byte (no bubble).
  - SEND_VAL: on acceptance -> DONE, or -> SEND_CHK when the checksum is compiled in.
  - SEND_CHK: on acceptance -> DONE.
  - DONE: tx_valid=0, done=1, busy=1 for exactly one cycle, then -> IDLE with done=0.
- Latency
  - enable at cycle N gives the first tx_valid at N+1.
  - With tx_ready held at 1, the last byte is accepted at N+2 (2-byte frame) or N+3 (3-byte frame).
  - done pulses the cycle after the last acceptance.
- Request handling
  - enable outside IDLE (including in DONE) is ignored, not queued.
  - Back-to-back queries therefore need enable to be re-asserted once busy=0.
- Simultaneous events
  - tx_ready=1 in the same cycle the byte first becomes valid counts as acceptance on that cycle.

Optional Feature:
REPORTBRIGHTNESS_CHECKSUM_EN
- Defined: the frame is 3 bytes: RESP_HEADER, value, then RESP_HEADER XOR value. The SEND_CHK state exists.
- Undefined: the frame is 2 bytes (header, value). SEND_CHK is absent and SEND_VAL acceptance goes directly to DONE.

Test Plan:
1. Reset, pulse brightness_change_en with brightness_in=6'h2A, later pulse enable with tx_ready=1 -> bytes 0x42, 0x2A on consecutive cycles, then done pulse. With REPORTBRIGHTNESS_CHECKSUM_EN the third byte is 0x68.
2. Backpressure: tx_ready=0 for 5 cycles after tx_valid rises -> tx_data holds 0x42 all 5 cycles. Then ready=1 -> 0x2A follows on the next cycle.
3. Bypass: brightness_change_en=1 with brightness_in=6'h15 in the same cycle as enable, stored value 0x2A -> value byte is 0x15.
4. Mid-frame update: during SEND_HDR with tx_ready=0, load 6'h3F -> the frame still reports the snapshot 0x15. The next query reports 0x3F.
5. enable asserted during SEND_VAL and during DONE -> ignored; exactly one frame emitted, done pulses once.
6. Reset asserted while tx_valid=1 in SEND_VAL -> after that edge tx_valid=0, busy=0, done=0. A subsequent query reports 0x00.

Source files
------------

// File: rtl/control_cmd_reportbrightness.sv
// Brightness report responder: tracks the committed brightness and, on query, sends a header/value frame over a valid/ready byte link.
// Optional build macro REPORTBRIGHTNESS_CHECKSUM_EN appends a header^value checksum byte.
module control_cmd_reportbrightness #(
  parameter int          BRIGHTNESS_LEVELS = 6,
  parameter logic [7:0]  RESP_HEADER       = 8'h42
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [BRIGHTNESS_LEVELS-1:0] brightness_in,
  input  logic                         brightness_change_en,
  input  logic                         enable,
  input  logic                         tx_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_HDR,
    SEND_VAL,
`ifdef REPORTBRIGHTNESS_CHECKSUM_EN
    SEND_CHK,
`endif
    DONE
  } state_t;

  state_t                         state, state_next;
  logic [BRIGHTNESS_LEVELS-1:0]   brightness_q;
  logic [BRIGHTNESS_LEVELS-1:0]   snapshot_q;
  logic [7:0]                     value_byte;
  logic                           accept;

  assign accept = tx_valid && tx_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      brightness_q <= '0;
      snapshot_q   <= '0;
    end else begin
      state <= state_next;
      if (brightness_change_en)
        brightness_q <= brightness_in;
      // A same-cycle update bypasses the register so the query reports the newest value.
      if (state == IDLE && enable)
        snapshot_q <= brightness_change_en ? brightness_in : brightness_q;
    end
  end

  // NOTE: each combinational output gets a default first so no path infers a latch.
  always_comb begin
    value_byte                          = '0;
    value_byte[BRIGHTNESS_LEVELS-1:0]   = snapshot_q;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (enable) state_next = SEND_HDR;
      SEND_HDR: if (accept) state_next = SEND_VAL;
`ifdef REPORTBRIGHTNESS_CHECKSUM_EN
      SEND_VAL: if (accept) state_next = SEND_CHK;
      SEND_CHK: if (accept) state_next = DONE;
`else
      SEND_VAL: if (accept) state_next = DONE;
`endif
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_data  = '0;
    tx_valid = 1'b0;
    busy     = (state != IDLE);
    done     = 1'b0;
    case (state)
      SEND_HDR: begin
        tx_valid = 1'b1;
        tx_data  = RESP_HEADER;
      end
      SEND_VAL: begin
        tx_valid = 1'b1;
        tx_data  = value_byte;
      end
`ifdef REPORTBRIGHTNESS_CHECKSUM_EN
      SEND_CHK: begin
        tx_valid = 1'b1;
        tx_data  = RESP_HEADER ^ value_byte;
      end
`endif
      DONE:     done = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_control_cmd_reportbrightness.sv
// Self-checking bench for control_cmd_reportbrightness: directed scenarios plus randomized frames against a frame-level model.
// Honours REPORTBRIGHTNESS_CHECKSUM_EN to expect the 3-byte frame.
module tb_control_cmd_reportbrightness;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] brightness_in;
  logic       brightness_change_en;
  logic       enable;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  // Model: the last committed brightness value.
  logic [5:0] stored;

  always #5 clk = ~clk;

  control_cmd_reportbrightness dut (
    .clk                  (clk),
    .reset                (reset),
    .brightness_in        (brightness_in),
    .brightness_change_en (brightness_change_en),
    .enable               (enable),
    .tx_ready             (tx_ready),
    .tx_data              (tx_data),
    .tx_valid             (tx_valid),
    .busy                 (busy),
    .done                 (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, tx_valid, 0);
    check({tag, "_busy"},  busy,     0);
    check({tag, "_done"},  done,     0);
    check({tag, "_data"},  tx_data,  0);
  endtask

  task automatic load(input logic [5:0] v);
    brightness_change_en = 1'b1;
    brightness_in        = v;
    stored               = v;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_frame(input bit bypass, input logic [5:0] byp_val, input int hdr_stall,
                           input int ready_pct, input bit noise, input bit stall_load,
                           input logic [5:0] stall_val);
    logic [7:0] exp_q[$];
    logic [7:0] vbyte;
    int idx   = 0;
    int stall = 0;
    int cyc   = 0;
    bit acc;
    enable = 1'b1;
    if (bypass) load(byp_val);
    vbyte = {2'b00, stored};
    exp_q = {8'h42, vbyte};
`ifdef REPORTBRIGHTNESS_CHECKSUM_EN
    exp_q.push_back(8'h42 ^ vbyte);
`endif
    @(negedge clk);
    enable = 1'b0;
    brightness_change_en = 1'b0;
    while (idx < exp_q.size() && cyc < 200) begin
      check("frame_valid", tx_valid, 1);
      check("frame_busy",  busy,     1);
      check("frame_done",  done,     0);
      check($sformatf("frame_byte%0d", idx), tx_data, exp_q[idx]);
      if (idx == 0 && stall < hdr_stall) begin
        tx_ready = 1'b0;
        if (stall_load && stall == 0) load(stall_val);
        stall++;
      end else begin
        tx_ready = ($urandom_range(99) < ready_pct);
      end
      if (noise) begin
        enable = 1'b1;
        if ($urandom_range(3) == 0) load(6'($urandom));
      end
      acc = tx_ready;
      @(negedge clk);
      enable = 1'b0;
      brightness_change_en = 1'b0;
      if (acc) idx++;
      cyc++;
    end
    check("frame_complete", idx, exp_q.size());
    tx_ready = 1'b0;
    check("done_valid", tx_valid, 0);
    check("done_pulse", done,     1);
    check("done_busy",  busy,     1);
    if (noise) enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    check("post_done",  done,     0);
    check("post_busy",  busy,     0);
    check("post_valid", tx_valid, 0);
    @(negedge clk);
    check("idle_busy",  busy,     0);
    check("idle_valid", tx_valid, 0);
  endtask

  initial begin
    reset = 1'b1;
    brightness_in = '0;
    brightness_change_en = 1'b0;
    enable = 1'b0;
    tx_ready = 1'b0;
    stored = '0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle("after_reset");

    // Basic frame with full throughput.
    load(6'h2A);
    @(negedge clk);
    brightness_change_en = 1'b0;
    repeat (2) @(negedge clk);
    run_frame(0, 6'h00, 0, 100, 0, 0, 6'h00);

    // Header backpressure for 5 cycles.
    run_frame(0, 6'h00, 5, 100, 0, 0, 6'h00);

    // Same-cycle update bypasses the stored value.
    run_frame(1, 6'h15, 0, 100, 0, 0, 6'h00);

    // Update during a stalled header must not alter the frame; next frame sees it.
    run_frame(0, 6'h00, 3, 100, 0, 1, 6'h3F);
    check("stored_model", {26'd0, stored}, 32'h3F);
    run_frame(0, 6'h00, 0, 100, 0, 0, 6'h00);

    // Queries while busy and in DONE are ignored.
    run_frame(0, 6'h00, 0, 100, 1, 0, 6'h00);

    // Reset while the value byte is pending aborts the frame.
    enable = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("rst_val_valid", tx_valid, 1);
    check("rst_val_data",  tx_data,  {2'b00, stored});
    tx_ready = 1'b0;
    reset = 1'b1;
    stored = '0;
    @(negedge clk);
    reset = 1'b0;
    check_idle("midframe_reset");
    @(negedge clk);
    check_idle("midframe_reset_hold");
    run_frame(0, 6'h00, 0, 100, 0, 0, 6'h00);

    // Randomized frames with random backpressure, bypass and mid-frame traffic.
    for (int n = 0; n < 25; n++) begin
      run_frame($urandom_range(1), 6'($urandom), $urandom_range(3),
                30 + $urandom_range(70), $urandom_range(1), 0, 6'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
